// File: rtl/mem_access_unit.sv
// Load/store access controller: byte/half/word accesses mapped onto a word-wide memory, using read-modify-write for sub-word stores.
// Latency: errors finish in 1 cycle, loads and sw in 2, sb/sh in 3; a req is only accepted in IDLE, and a req seen while busy is dropped.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              st,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              done,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_A,
    output logic              mem_WE,
    output logic [31:0]       mem_WD,
    input  logic [31:0]       mem_RD
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_st;
    logic [2:0]        r_funct3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_word;
    logic [31:0]       r_rdata;

    logic              w_bad;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;
    logic [31:0]       w_merge;

    // Legality and alignment are judged on the live inputs, because they choose the branch taken out of IDLE.
    always_comb begin
        w_bad = 1'b0;
        case (funct3)
            3'b000:  w_bad = 1'b0;
            3'b001:  w_bad = addr[0];
            3'b010:  w_bad = (addr[1:0] != 2'b00);
            3'b100:  w_bad = st;
            3'b101:  w_bad = st | addr[0];
            default: w_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        done   = 1'b0;
        err    = 1'b0;
        busy   = 1'b1;
        mem_A  = '0;
        mem_WE = 1'b0;
        mem_WD = '0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (req) begin
                    if (w_bad)
                        w_next = S_ERR;
                    else if (st && funct3 == 3'b010)
                        w_next = S_WRITE;
                    else
                        w_next = S_READ;
                end
            end
            S_READ: begin
                mem_A  = {r_addr[ADDR_W-1:2], 2'b00};
                w_next = r_st ? S_WRITE : S_DONE;
            end
            S_WRITE: begin
                mem_A  = {r_addr[ADDR_W-1:2], 2'b00};
                mem_WE = 1'b1;
                mem_WD = w_merge;
                w_next = S_DONE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                done   = 1'b1;
                err    = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Lane extraction for loads; funct3[2] marks the unsigned variants.
    always_comb begin
        w_byte = mem_RD[{r_addr[1:0], 3'b000} +: 8];
        w_half = r_addr[1] ? mem_RD[31:16] : mem_RD[15:0];
        case (r_funct3[1:0])
            2'b00:   w_load = {{24{w_byte[7] & ~r_funct3[2]}}, w_byte};
            2'b01:   w_load = {{16{w_half[15] & ~r_funct3[2]}}, w_half};
            default: w_load = mem_RD;
        endcase
    end

    // sw skips READ, so r_word is stale there and the whole word comes from r_wdata.
    always_comb begin
        w_merge = r_word;
        case (r_funct3[1:0])
            2'b00: w_merge[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            2'b01: begin
                if (r_addr[1])
                    w_merge[31:16] = r_wdata[15:0];
                else
                    w_merge[15:0] = r_wdata[15:0];
            end
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_st     <= 1'b0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
        end else begin
            if (r_state == S_IDLE && req) begin
                r_st     <= st;
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
            end
            if (r_state == S_READ) begin
                r_word <= mem_RD;
                if (!r_st)
                    r_rdata <= w_load;
            end
        end
    end

    assign rdata = r_rdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a word-array memory plus a byte-level reference model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        st;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        done;
    logic        err;
    logic        busy;
    logic [31:0] mem_A;
    logic        mem_WE;
    logic [31:0] mem_WD;
    logic [31:0] mem_RD;

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];
    logic        mem_init;
    logic [31:0] exp_rdata;
    int          n_vec = 0;
    int          n_bad = 0;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .st     (st),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .done   (done),
        .err    (err),
        .busy   (busy),
        .mem_A  (mem_A),
        .mem_WE (mem_WE),
        .mem_WD (mem_WD),
        .mem_RD (mem_RD)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] seed_word(input int i);
        if (i == 64)
            return 32'h8899AABB;
        return (32'(i) * 32'h9E3779B1) ^ 32'hA5A50F0F;
    endfunction

    assign mem_RD = mem[mem_A[9:2]];

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++)
                mem[i] <= seed_word(i);
        end else if (mem_WE) begin
            mem[mem_A[9:2]] <= mem_WD;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // One access: expectations come from byte-level rules applied to ref_mem, then the DUT is observed on negedges.
    task automatic access(input logic s, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input bit hold);
        int          size;
        int          sh;
        bit          legal;
        bit          bad;
        int          lat;
        int          k;
        int          we_cnt;
        int          we_k;
        logic [63:0] mask;
        logic [31:0] w;
        logic [31:0] val;
        logic [31:0] nw;
        size  = 1 << f[1:0];
        legal = (f == 3'd0 || f == 3'd1 || f == 3'd2 || (!s && (f == 3'd4 || f == 3'd5)));
        bad   = !legal || ((a % size) != 0);
        sh    = 8 * (a % 4);
        w     = ref_mem[a[9:2]];
        mask  = (64'd1 << (8 * size)) - 64'd1;
        val   = (w >> sh) & mask[31:0];
        if (f < 3'd4 && size < 4 && val[8*size-1])
            val = val | ~mask[31:0];
        nw  = (w & ~(mask[31:0] << sh)) | ((d & mask[31:0]) << sh);
        lat = bad ? 1 : ((!s || size == 4) ? 2 : 3);

        @(negedge clk);
        st = s; funct3 = f; addr = a; wdata = d; req = 1'b1;
        @(posedge clk);
        #1;
        if (!hold)
            req = 1'b0;
        we_cnt = 0;
        we_k   = 0;
        for (k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (mem_WE) begin
                we_cnt++;
                we_k = k;
                chk("mem_A", mem_A, {22'd0, a[9:2], 2'b00});
                chk("mem_WD", mem_WD, nw);
            end
            if (done)
                break;
        end
        req = 1'b0;
        if (!bad && !s)
            exp_rdata = val;
        chk("latency", 32'(k), 32'(lat));
        chk("err", {31'd0, err}, {31'd0, bad});
        chk("rdata", rdata, exp_rdata);
        chk("idle_bus", mem_A | mem_WD, 32'd0);
        chk("we_count", 32'(we_cnt), (!bad && s) ? 32'd1 : 32'd0);
        if (!bad && s) begin
            chk("we_cycle", 32'(we_k), 32'(lat - 1));
            ref_mem[a[9:2]] = nw;
        end
        @(negedge clk);
        chk("after_done", {30'd0, done, busy}, 32'd0);
        chk("mem_word", mem[a[9:2]], ref_mem[a[9:2]]);
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; st = 1'b0; funct3 = '0; addr = '0; wdata = '0;
        mem_init  = 1'b1;
        exp_rdata = 32'd0;
        for (int i = 0; i < 256; i++)
            ref_mem[i] = seed_word(i);
        @(posedge clk);
        #1 mem_init = 1'b0;
        @(negedge clk);
        chk("reset_rdata", rdata, 32'd0);
        chk("reset_flags", {29'd0, done, err, busy}, 32'd0);
        chk("reset_bus", mem_A | mem_WD | {31'd0, mem_WE}, 32'd0);
        rst = 1'b0;

        // Directed loads/stores on word 0x100 = 0x8899AABB.
        access(1'b0, 3'b000, 32'h101, 32'h0, 1'b0);
        chk("tp_lb", rdata, 32'hFFFFFFAA);
        access(1'b0, 3'b100, 32'h103, 32'h0, 1'b0);
        chk("tp_lbu", rdata, 32'h00000088);
        access(1'b0, 3'b001, 32'h102, 32'h0, 1'b0);
        chk("tp_lh", rdata, 32'hFFFF8899);
        access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        chk("tp_lw", rdata, 32'h8899AABB);
        access(1'b1, 3'b000, 32'h102, 32'h12345677, 1'b0);
        chk("tp_sb", mem[64], 32'h8877AABB);
        access(1'b1, 3'b001, 32'h100, 32'h0000CAFE, 1'b0);
        chk("tp_sh", mem[64], 32'h8877CAFE);
        access(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 1'b0);
        access(1'b0, 3'b010, 32'h104, 32'h0, 1'b0);
        chk("tp_sw_rb", rdata, 32'hDEADBEEF);
        access(1'b0, 3'b010, 32'h102, 32'h0, 1'b0);
        access(1'b1, 3'b001, 32'h103, 32'h5555, 1'b0);
        access(1'b0, 3'b011, 32'h100, 32'h0, 1'b0);
        chk("tp_err_rdata", rdata, 32'hDEADBEEF);
        access(1'b1, 3'b000, 32'h109, 32'hA5, 1'b1);
        access(1'b0, 3'b101, 32'h10A, 32'h0, 1'b1);

        // Reset during READ (n=1) and during WRITE (n=2) of an sb must leave memory untouched.
        for (int n = 1; n <= 2; n++) begin
            @(negedge clk);
            st = 1'b1; funct3 = 3'b000; addr = 32'h102; wdata = 32'h0000003C; req = 1'b1;
            @(posedge clk);
            #1 req = 1'b0;
            for (int j = 0; j < n; j++)
                @(negedge clk);
            chk("pre_rst_busy", {31'd0, busy}, 32'd1);
            chk("pre_rst_we", {31'd0, mem_WE}, (n == 2) ? 32'd1 : 32'd0);
            rst = 1'b1;
            #1;
            chk("rst_we", {31'd0, mem_WE}, 32'd0);
            chk("rst_flags", {29'd0, done, err, busy}, 32'd0);
            chk("rst_bus", mem_A | mem_WD, 32'd0);
            chk("rst_rdata", rdata, 32'd0);
            exp_rdata = 32'd0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            chk("rst_mem", mem[64], ref_mem[64]);
            access(1'b0, 3'b010, 32'h100, 32'h0, 1'b0);
        end

        for (int i = 0; i < 300; i++) begin
            access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 1023)), $urandom, ($urandom_range(0, 7) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
